// File: rtl/count_checker_pkg.sv
// Shared definitions for the counter generator / checker pair.
// Holds the checker FSM state encoding and the default widths that the
// generator and checker must agree on.
package count_checker_pkg;

    // Default sample width (must match the generator) and error counter width.
    localparam int DEF_N     = 4;
    localparam int DEF_ERR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/count_checker_sat.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (count -> 0)
//   inc   - count up by one this cycle (held at all-ones once saturated)
//   clr   - zero the count; wins over a simultaneous inc
//   count - registered count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/count_checker.sv
// count_checker: receive-side monitor for a free-running N-bit counter stream.
// Seeds on the first valid sample, declares lock after LOCK_CNT consecutive
// in-sequence samples (seed included), then flags every out-of-sequence
// sample. While locked the expected value free-runs (flywheel) so one bad
// sample does not corrupt the reference; LOSS_CNT consecutive bad samples
// drop back to searching, reseeded from the latest sample.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   in_valid  - in_data carries a sample this cycle
//   in_data   - counter sample
//   clear     - zero err_count next cycle (wins over an increment)
//   locked    - registered, high while in LOCKED
//   err_pulse - registered one-cycle pulse per mismatched sample while LOCKED
//   err_count - registered saturating mismatch count
module count_checker
    import count_checker_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(LOSS_CNT + 1);

    state_e           state_q, state_d;
    logic [N-1:0]     exp_q, exp_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [BAD_W-1:0] bad_q, bad_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_inc;

    logic [N-1:0]     seed;
    logic [RUN_W-1:0] run_p1;
    logic [BAD_W-1:0] bad_p1;
    logic             match;

    assign seed   = in_data + N'(1);
    assign run_p1 = run_q + RUN_W'(1);
    assign bad_p1 = bad_q + BAD_W'(1);
    assign match  = (in_data == exp_q);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    exp_d   = seed;
                    run_d   = RUN_W'(1);
                    state_d = SEEK;
                end
                SEEK: begin
                    // Both outcomes follow the sample; a mismatch just
                    // restarts the run from this sample as the new seed.
                    exp_d = seed;
                    if (match) begin
                        run_d = run_p1;
                        if (run_p1 == RUN_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        run_d = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    exp_d = exp_q + N'(1);
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        bad_d       = bad_p1;
                        if (bad_p1 == BAD_W'(LOSS_CNT)) begin
                            state_d = SEEK;
                            run_d   = RUN_W'(1);
                            exp_d   = seed;
                            bad_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            run_q       <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clear),
        .count (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        clear = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s;
    logic [1:0]  err_count_s;

    int n_chk = 0;
    int n_pass = 0;

    // Behavioural reference: 0=idle 1=seek 2=locked
    int m_st = 0, m_exp = 0, m_run = 0, m_bad = 0;
    int m_cnt = 0, m_cnt_s = 0;
    bit m_pulse = 0, m_locked = 0;

    always #5 clk = ~clk;

    count_checker #(.N(4), .ERR_W(16), .LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    count_checker #(.N(4), .ERR_W(2), .LOCK_CNT(4), .LOSS_CNT(3)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
    );

    task automatic model_update(input bit v, input int d, input bit c, input bit r);
        bit err = 0;
        if (r) begin
            m_st = 0; m_exp = 0; m_run = 0; m_bad = 0;
            m_cnt = 0; m_cnt_s = 0; m_pulse = 0; m_locked = 0;
            return;
        end
        if (v) begin
            if (m_st == 0) begin
                m_exp = (d + 1) % 16; m_run = 1; m_st = 1;
            end else if (m_st == 1) begin
                if (d == m_exp) begin
                    m_run++;
                    if (m_run == 4) begin m_st = 2; m_bad = 0; end
                end else m_run = 1;
                m_exp = (d + 1) % 16;
            end else begin
                if (d == m_exp) m_bad = 0;
                else begin err = 1; m_bad++; end
                m_exp = (m_exp + 1) % 16;
                if (m_bad == 3) begin
                    m_st = 1; m_run = 1; m_exp = (d + 1) % 16; m_bad = 0;
                end
            end
        end
        m_pulse = err;
        if (c) begin m_cnt = 0; m_cnt_s = 0; end
        else if (err) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end
        m_locked = (m_st == 2);
    endtask

    task automatic step(input bit v, input int d, input bit c = 0, input bit r = 0);
        @(negedge clk);
        in_valid = v; in_data = 4'(d); clear = c; reset = r;
        model_update(v, d, c, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        n_chk++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0)
            $display("FAIL reset: locked=%b pulse=%b cnt=%0d, want 0/0/0", locked, err_pulse, err_count);
        else n_pass++;
        n_chk++;
        if (locked_s !== 1'b0 || err_pulse_s !== 1'b0 || err_count_s !== 2'd0)
            $display("FAIL reset_s: locked=%b pulse=%b cnt=%0d, want 0/0/0", locked_s, err_pulse_s, err_count_s);
        else n_pass++;
    endtask

    task automatic test_lock();
        int  seq[4]   = '{5, 6, 7, 8};
        bit  want[4]  = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(1, seq[i]);
            n_chk++;
            if (locked !== want[i] || err_pulse !== 1'b0 || err_count !== 16'd0)
                $display("FAIL lock[%0d]: locked=%b pulse=%b cnt=%0d, want %b/0/0",
                         i, locked, err_pulse, err_count, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_gaps();
        // expected is 9; walk to 14, then wrap through 15->0 with idle gaps
        for (int d = 9; d <= 13; d++) step(1, d);
        step(1, 14);
        step(0, 3);
        step(0, 11);
        step(1, 15);
        step(1, 0);
        step(1, 1);
        n_chk++;
        if (locked !== 1'b1 || err_pulse !== 1'b0 || err_count !== 16'd0)
            $display("FAIL wrap: locked=%b pulse=%b cnt=%0d, want 1/0/0", locked, err_pulse, err_count);
        else n_pass++;
    endtask

    task automatic test_single_error();
        step(1, 2);   // expected now 3
        step(1, 3);
        step(1, 9);
        n_chk++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1)
            $display("FAIL single_err: pulse=%b cnt=%0d locked=%b, want 1/1/1", err_pulse, err_count, locked);
        else n_pass++;
        step(1, 5);
        n_chk++;
        if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1)
            $display("FAIL flywheel: pulse=%b cnt=%0d locked=%b, want 0/1/1", err_pulse, err_count, locked);
        else n_pass++;
    endtask

    task automatic test_loss_relock();
        bit want_l[3] = '{1, 1, 0};
        bit want_r[3] = '{0, 0, 1};
        for (int d = 6; d <= 15; d++) step(1, d);   // expected now 0
        step(0, 0, 1);                              // clear
        n_chk++;
        if (err_count !== 16'd0)
            $display("FAIL clear_idle: cnt=%0d, want 0", err_count);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1, 7);
            n_chk++;
            if (err_pulse !== 1'b1 || err_count !== 16'(i + 1) || locked !== want_l[i])
                $display("FAIL loss[%0d]: pulse=%b cnt=%0d locked=%b, want 1/%0d/%b",
                         i, err_pulse, err_count, locked, i + 1, want_l[i]);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 8 + i);
            n_chk++;
            if (err_pulse !== 1'b0 || err_count !== 16'd3 || locked !== want_r[i])
                $display("FAIL relock[%0d]: pulse=%b cnt=%0d locked=%b, want 0/3/%b",
                         i, err_pulse, err_count, locked, want_r[i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation_clear();
        int e = 11;
        logic [1:0] want[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, (e + 5) % 16);                  // bad sample
            e = (e + 1) % 16;
            n_chk++;
            if (err_pulse_s !== 1'b1 || err_count_s !== want[i] || locked_s !== 1'b1)
                $display("FAIL sat[%0d]: pulse=%b cnt=%0d locked=%b, want 1/%0d/1",
                         i, err_pulse_s, err_count_s, locked_s, want[i]);
            else n_pass++;
            if (i < 3) begin
                step(1, e);                         // good sample
                e = (e + 1) % 16;
            end
        end
        step(1, (e + 7) % 16, 1);                   // bad + clear
        n_chk++;
        if (err_pulse_s !== 1'b1 || err_count_s !== 2'd0 || err_count !== 16'd0 || err_pulse !== 1'b1)
            $display("FAIL clr_prio: pulse=%b cnt_s=%0d cnt=%0d, want 1/0/0", err_pulse_s, err_count_s, err_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_lock();
        bit want[4] = '{0, 0, 0, 1};
        step(1, 3);
        step(1, 0);
        step(1, 5);
        step(1, 0);
        n_chk++;
        if (locked !== 1'b1 || err_count !== 16'd2)
            $display("FAIL pre_reset: locked=%b cnt=%0d, want 1/2", locked, err_count);
        else n_pass++;
        step(1, 7, 0, 1);
        n_chk++;
        if (locked !== 1'b0 || err_count !== 16'd0 || err_pulse !== 1'b0)
            $display("FAIL mid_reset: locked=%b cnt=%0d pulse=%b, want 0/0/0", locked, err_count, err_pulse);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(1, 4 + i);
            n_chk++;
            if (locked !== want[i] || err_pulse !== 1'b0)
                $display("FAIL reseed[%0d]: locked=%b pulse=%b, want %b/0", i, locked, err_pulse, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit v = ($urandom_range(0, 9) < 7);
            int d = ($urandom_range(0, 9) < 8) ? m_exp : int'($urandom_range(0, 15));
            bit c = ($urandom_range(0, 39) == 0);
            bit r = ($urandom_range(0, 149) == 0);
            step(v, d, c, r);
            n_chk++;
            if (locked !== m_locked || err_pulse !== m_pulse || err_count !== 16'(m_cnt))
                $display("FAIL rand[%0d]: got %b/%b/%0d, want %b/%b/%0d",
                         i, locked, err_pulse, err_count, m_locked, m_pulse, m_cnt);
            else n_pass++;
            n_chk++;
            if (locked_s !== m_locked || err_pulse_s !== m_pulse || err_count_s !== 2'(m_cnt_s))
                $display("FAIL rand_s[%0d]: got %b/%b/%0d, want %b/%b/%0d",
                         i, locked_s, err_pulse_s, err_count_s, m_locked, m_pulse, m_cnt_s);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap_gaps();
        test_single_error();
        test_loss_relock();
        test_saturation_clear();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
